// File: rtl/mux7_rr_scheduler.sv
// Round-robin scheduler that owns the select of a 7:1 data mux: one requester at a
// time gets a bounded burst, followed by an optional guard gap before re-arbitration.
module mux7_rr_scheduler #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [6:0] req,
  input  logic       release_i,
  output logic [6:0] gnt,
  output logic [2:0] sel,
  output logic       sel_valid,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0] state;
  logic [2:0] last_ptr;
  logic [3:0] hold_cnt;
  logic [3:0] gap_cnt;

  logic       found;
  logic [2:0] winner;
  logic [3:0] probe;
  logic       burst_end;

  // Search upward from last_ptr+1 (mod 7); scanning farthest-first lets the nearest hit win.
  // NOTE: every variable gets a default before the loop so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    found  = 1'b0;
    winner = last_ptr;
    probe  = '0;
    for (int k = 7; k >= 1; k--) begin
      probe = {1'b0, last_ptr} + 4'(k);
      if (probe >= 4'd7) probe = probe - 4'd7;
      if (req[probe[2:0]]) begin
        found  = 1'b1;
        winner = probe[2:0];
      end
    end
  end

  assign burst_end = (hold_cnt == 4'(HOLD_CYCLES)) || release_i || !req[sel];
  assign busy      = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      last_ptr  <= 3'd6;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && found) begin
            state     <= ST_GRANT;
            gnt       <= 7'(1) << winner;
            sel       <= winner;
            sel_valid <= 1'b1;
            last_ptr  <= winner;
            hold_cnt  <= 4'd1;
          end
        end
        ST_GRANT: begin
          if (burst_end) begin
            // sel is left untouched so the mux select never glitches on exit.
            gnt       <= '0;
            sel_valid <= 1'b0;
            hold_cnt  <= '0;
            if (GAP_CYCLES == 0) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= 4'd1;
            end
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 4'(GAP_CYCLES)) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux7_rr_scheduler.sv
// Bench for mux7_rr_scheduler: two instances (default timing and a short-burst,
// no-gap variant) checked every cycle against a burst-level reference model.
module tb_mux7_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [6:0] req;
  logic       release_i;

  logic [6:0] gnt0, gnt1;
  logic [2:0] sel0, sel1;
  logic       sel_valid0, sel_valid1;
  logic       busy0, busy1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux7_rr_scheduler #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .release_i(release_i),
    .gnt(gnt0), .sel(sel0), .sel_valid(sel_valid0), .busy(busy0)
  );

  mux7_rr_scheduler #(.HOLD_CYCLES(2), .GAP_CYCLES(0)) dut_nogap (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .release_i(release_i),
    .gnt(gnt1), .sel(sel1), .sel_valid(sel_valid1), .busy(busy1)
  );

  // Data inputs of the downstream mux: in0..in6 = 0,1,1,1,0,1,0
  logic [6:0] mux_in = 7'b0101110;
  int         z_ref [7] = '{0, 1, 1, 1, 0, 1, 0};
  logic       z;
  assign z = mux_in[sel0];

  // Reference model: who owns the mux, how long the burst has run, gap remaining.
  int hold_p [2] = '{4, 2};
  int gap_p  [2] = '{1, 0};
  int m_owner [2];
  int m_len   [2];
  int m_gap   [2];
  int m_ptr   [2];
  int m_sel   [2];

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_owner[u] = -1;
      m_len[u]   = 0;
      m_gap[u]   = 0;
      m_ptr[u]   = 6;
      m_sel[u]   = 0;
    end
  endtask

  task automatic model_step();
    for (int u = 0; u < 2; u++) begin
      if (m_owner[u] >= 0) begin
        if (m_len[u] == hold_p[u] || release_i || !req[m_owner[u]]) begin
          m_owner[u] = -1;
          m_gap[u]   = gap_p[u];
        end else begin
          m_len[u] = m_len[u] + 1;
        end
      end else if (m_gap[u] > 0) begin
        m_gap[u] = m_gap[u] - 1;
      end else if (enable && req != 7'd0) begin
        for (int k = 1; k <= 7; k++) begin
          if (req[(m_ptr[u] + k) % 7]) begin
            m_owner[u] = (m_ptr[u] + k) % 7;
            break;
          end
        end
        m_ptr[u] = m_owner[u];
        m_sel[u] = m_owner[u];
        m_len[u] = 1;
      end
    end
  endtask

  function automatic logic [6:0] exp_gnt(int u);
    return (m_owner[u] >= 0) ? (7'd1 << m_owner[u]) : 7'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_all();
    check("u0_gnt",       32'(gnt0),       32'(exp_gnt(0)));
    check("u0_sel",       32'(sel0),       32'(m_sel[0]));
    check("u0_sel_valid", 32'(sel_valid0), 32'(m_owner[0] >= 0));
    check("u0_busy",      32'(busy0),      32'(m_owner[0] >= 0 || m_gap[0] > 0));
    check("u0_onehot",    32'($onehot0(gnt0)), 32'd1);
    check("u1_gnt",       32'(gnt1),       32'(exp_gnt(1)));
    check("u1_sel",       32'(sel1),       32'(m_sel[1]));
    check("u1_sel_valid", 32'(sel_valid1), 32'(m_owner[1] >= 0));
    check("u1_busy",      32'(busy1),      32'(m_owner[1] >= 0 || m_gap[1] > 0));
    if (sel_valid0) check("u0_mux_z", 32'(z), 32'(z_ref[m_owner[0] < 0 ? 0 : m_owner[0]]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Reset asserted in the middle of a cycle; outputs must clear with no clock edge.
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_gnt",       32'(gnt0),       32'd0);
    check("rst_sel",       32'(sel0),       32'd0);
    check("rst_sel_valid", 32'(sel_valid0), 32'd0);
    check("rst_busy",      32'(busy0),      32'd0);
    check("rst_gnt_nogap", 32'(gnt1),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [2:0] grant_seq [$];
  logic       prev_valid;

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    req       = '0;
    release_i = 1'b0;
    model_reset();
    #3;
    check("init_gnt",  32'(gnt0),  32'd0);
    check("init_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single requester: 4-cycle burst, one gap cycle, then idle.
    req    = 7'b0000100;
    enable = 1'b1;
    tick();
    check("single_gnt", 32'(gnt0), 32'b0000100);
    check("single_sel", 32'(sel0), 32'd2);
    tick(); tick(); tick();
    check("single_hold4", 32'(sel_valid0), 32'd1);
    tick();
    check("single_end_gnt", 32'(gnt0), 32'd0);
    check("single_gap_busy", 32'(busy0), 32'd1);
    tick();
    check("single_idle_busy", 32'(busy0), 32'd0);
    tick();
    check("single_regrant", 32'(gnt0), 32'b0000100);
    tick();

    // Asynchronous reset in the middle of a burst.
    do_reset();
    req = '0;
    tick();
    check("no_resume", 32'(gnt0), 32'd0);

    // Round robin with all requesters active, starting from requester 0.
    req        = 7'h7f;
    prev_valid = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (sel_valid0 && !prev_valid) grant_seq.push_back(sel0);
      prev_valid = sel_valid0;
    end
    check("rr_count_ok", 32'(grant_seq.size() >= 8), 32'd1);
    for (int k = 0; k < 8 && k < grant_seq.size(); k++)
      check("rr_order", 32'(grant_seq[k]), 32'(k % 7));

    // Early end by dropping the request on the burst's second cycle.
    do_reset();
    req = 7'b0001000;
    tick();
    check("early_sel", 32'(sel0), 32'd3);
    tick();
    req = '0;
    tick();
    check("drop_gnt", 32'(gnt0), 32'd0);
    check("drop_sel_kept", 32'(sel0), 32'd3);
    tick(); tick();

    // Early end by release_i on the first cycle: one-cycle burst.
    req = 7'b0001000;
    tick();
    check("rel_gnt_on", 32'(gnt0), 32'b0001000);
    release_i = 1'b1;
    tick();
    release_i = 1'b0;
    check("rel_gnt_off", 32'(gnt0), 32'd0);
    req = '0;
    tick(); tick(); tick();

    // enable gates new grants only; a running burst completes.
    enable = 1'b0;
    req    = 7'b0010000;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("disabled_gnt", 32'(gnt0), 32'd0);
    end
    enable = 1'b1;
    tick();
    check("enable_gnt", 32'(gnt0), 32'b0010000);
    enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("burst_continues", 32'(sel_valid0), 32'd1);
    end
    tick();
    check("burst_done", 32'(gnt0), 32'd0);
    tick(); tick();

    // Mux integration: z follows the selected data input during each burst.
    do_reset();
    enable = 1'b1;
    req    = 7'h7f;
    for (int c = 0; c < 45; c++) tick();

    // Randomized traffic with occasional mid-cycle resets.
    for (int c = 0; c < 800; c++) begin
      req       = 7'($urandom);
      enable    = ($urandom_range(7) != 0);
      release_i = ($urandom_range(5) == 0);
      if ($urandom_range(96) == 0) do_reset();
      else tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
